if_id_fetch: RTL and testbench

// - Fetch-stage control and IF/ID pipeline register for the single-issue MIPS datapath.
// - Feeds the program counter: computes its next Address from PCResult, stall and redirect inputs.
// - Consumes PCResult and the instruction memory read data.
// - Registers the IF/ID payload toward decode.
// - Holds a redirect that arrives while stalled and applies it when the stall releases.

---
 rtl/if_id_fetch.sv | 105 ++++++++++
 tb/tb_if_id_fetch.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_id_fetch.sv
// Fetch-stage control for the single-issue MIPS datapath: next-PC selection,
// a held redirect across stalls, and the IF/ID pipeline register.
//
// state   | meaning
// IDLE    | no redirect waiting
// PENDING | a redirect arrived during a stall; target held until release
module if_id_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Address,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        RedirectPending
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    state_t      state, state_next;
    logic [31:0] pend_target;
    logic [31:0] pc_plus4;
    logic [31:0] jump_aligned;
    logic [31:0] branch_aligned;
    logic [31:0] live_target;
    logic        live_redirect;
    logic        redirect_applied;

    assign pc_plus4       = PCResult + 32'd4;
    assign jump_aligned   = {JumpTarget[31:2], 2'b00};
    assign branch_aligned = {BranchTarget[31:2], 2'b00};
    assign live_redirect  = Jump | BranchTaken;
    assign live_target    = Jump ? jump_aligned : branch_aligned;
    assign redirect_applied = !Stall && (live_redirect || (state == PENDING));

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Stall && live_redirect) state_next = PENDING;
            PENDING: if (!Stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        RedirectPending = (state == PENDING);
    end

    // The latest redirect seen during a stall wins; cleared once the stall releases.
    always_ff @(posedge Clk) begin
        if (Reset)
            pend_target <= 32'h0;
        else if (Stall && live_redirect)
            pend_target <= live_target;
        else if (!Stall)
            pend_target <= 32'h0;
    end

    always_comb begin
        Address = pc_plus4;
        if (Reset)
            Address = RESET_PC;
        else if (Stall)
            Address = PCResult;
        else if (live_redirect)
            Address = live_target;
        else if (state == PENDING)
            Address = pend_target;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCPlus4 <= 32'h0;
            IF_ID_Valid   <= 1'b0;
        end else if (!Stall) begin
            IF_ID_PCPlus4 <= pc_plus4;
            if (redirect_applied && !DELAY_SLOT) begin
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end else begin
                IF_ID_Instr <= Instruction;
                IF_ID_Valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed bench for if_id_fetch: a flush-on-redirect instance and a
// delay-slot instance share the same stimulus.
module tb_if_id_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCResult, Instruction, BranchTarget, JumpTarget;
    logic        Stall, BranchTaken, Jump;
    logic [31:0] Address, IF_ID_Instr, IF_ID_PCPlus4;
    logic        IF_ID_Valid, RedirectPending;
    logic [31:0] ds_Address, ds_Instr, ds_PCPlus4;
    logic        ds_Valid, ds_Pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    if_id_fetch #(.DELAY_SLOT(1'b0)) dut (
        .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Instruction(Instruction),
        .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Address(Address),
        .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid(IF_ID_Valid), .RedirectPending(RedirectPending)
    );

    if_id_fetch #(.DELAY_SLOT(1'b1)) dut_ds (
        .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Instruction(Instruction),
        .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Address(ds_Address),
        .IF_ID_Instr(ds_Instr), .IF_ID_PCPlus4(ds_PCPlus4),
        .IF_ID_Valid(ds_Valid), .RedirectPending(ds_Pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, "_instr"}, IF_ID_Instr, instr);
        check({tag, "_pc4"}, IF_ID_PCPlus4, pc4);
        check({tag, "_valid"}, {31'b0, IF_ID_Valid}, {31'b0, valid});
    endtask

    initial begin
        Reset = 1'b1; PCResult = 32'h0; Instruction = 32'h0;
        Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
        Jump = 1'b0; JumpTarget = 32'h0;
        tick();
        tick();
        check("rst_addr", Address, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst_pend", {31'b0, RedirectPending}, 32'h0);

        // Release reset, first fetch
        Reset = 1'b0; Instruction = 32'h2001_0005; #1;
        check("first_addr", Address, 32'h4);
        tick();
        check_ifid("first", 32'h2001_0005, 32'h4, 1'b1);

        // Stall holds PC and IF/ID
        PCResult = 32'h40; Instruction = 32'h1111_1111; Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_addr", Address, 32'h40);
            tick();
            check_ifid("stall", 32'h2001_0005, 32'h4, 1'b1);
        end

        // Taken branch with misaligned target
        Stall = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h103; Instruction = 32'h2222_2222; #1;
        check("br_addr", Address, 32'h100);
        check("br_addr_ds", ds_Address, 32'h100);
        tick();
        check_ifid("br_flush", 32'h0, 32'h44, 1'b0);
        check("br_ds_instr", ds_Instr, 32'h2222_2222);
        check("br_ds_valid", {31'b0, ds_Valid}, 32'h1);

        // Sequential fetch after branch
        BranchTaken = 1'b0; PCResult = 32'h100; Instruction = 32'h3333_3333; #1;
        check("seq_addr", Address, 32'h104);
        tick();
        check_ifid("seq", 32'h3333_3333, 32'h104, 1'b1);

        // Jump then branch during stall: last one wins
        PCResult = 32'h104; Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h200; #1;
        check("pj_addr", Address, 32'h104);
        tick();
        check("pj_pend", {31'b0, RedirectPending}, 32'h1);
        Jump = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h300; #1;
        check("pb_addr", Address, 32'h104);
        tick();
        check("pb_pend", {31'b0, RedirectPending}, 32'h1);
        check_ifid("pb_hold", 32'h3333_3333, 32'h104, 1'b1);
        Stall = 1'b0; BranchTaken = 1'b0; #1;
        check("rel_addr", Address, 32'h300);
        tick();
        check("rel_pend", {31'b0, RedirectPending}, 32'h0);
        check_ifid("rel_flush", 32'h0, 32'h108, 1'b0);
        PCResult = 32'h300; #1;
        check("post_rel_addr", Address, 32'h304);

        // Live jump overrides a pending target at release
        Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h500;
        tick();
        check("ov_pend", {31'b0, RedirectPending}, 32'h1);
        Stall = 1'b0; JumpTarget = 32'h600; #1;
        check("ov_addr", Address, 32'h600);
        tick();
        check("ov_pend_clr", {31'b0, RedirectPending}, 32'h0);
        Jump = 1'b0; PCResult = 32'h600; #1;
        check("ov_drop_addr", Address, 32'h604);

        // Jump beats branch in the same cycle
        Jump = 1'b1; JumpTarget = 32'h801; BranchTaken = 1'b1; BranchTarget = 32'h900; #1;
        check("jb_addr", Address, 32'h800);
        tick();
        Jump = 1'b0; BranchTaken = 1'b0;

        // PC+4 wraps at the top of the address space
        PCResult = 32'hFFFF_FFFC; Instruction = 32'h4444_4444; #1;
        check("wrap_addr", Address, 32'h0);
        tick();
        check_ifid("wrap", 32'h4444_4444, 32'h0, 1'b1);

        // Reset mid-stall clears a pending redirect
        PCResult = 32'h10; Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h700;
        tick();
        check("rs_pend", {31'b0, RedirectPending}, 32'h1);
        Reset = 1'b1; #1;
        check("rs_addr", Address, 32'h0);
        tick();
        check("rs_pend_clr", {31'b0, RedirectPending}, 32'h0);
        check_ifid("rs", 32'h0, 32'h0, 1'b0);
        Reset = 1'b0; Stall = 1'b0; Jump = 1'b0; PCResult = 32'h8; #1;
        check("rs_after_addr", Address, 32'hC);
        tick();
        check("rs_after_valid", {31'b0, IF_ID_Valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
